gam_pattern_feeder: RTL and testbench

- Training-pattern source placed directly upstream of Memory_Layer.
- Holds a small bank of node vectors indexed by class and node, loaded through a write port.
- On start, streams the vectors to Memory_Layer one per READY handshake, driving x and c.
- Asserts learning_done with the last pattern, then switches learning_recall to RECALL.

---
 rtl/gam_pattern_feeder.sv | 179 +++++++++++++++++
 tb/tb_gam_pattern_feeder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/gam_pattern_feeder.sv
// Training-pattern source for Memory_Layer: a bank of class/node vectors streamed one per READY edge.
// Optional GAM_ZERO_SKIP_EN: zero vectors are skipped instead of issued.
module gam_pattern_feeder #(
    parameter int NODE_W          = 32,
    parameter int NUM_CLASSES     = 4,
    parameter int NODES_PER_CLASS = 5,
    parameter int IDX_W           = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_en,
    input  logic [IDX_W-1:0]  ld_class,
    input  logic [IDX_W-1:0]  ld_node,
    input  logic [NODE_W-1:0] ld_data,
    output logic              ld_err,
    input  logic              start,
    input  logic              ready_wait,
    output logic [NODE_W-1:0] x,
    output logic [31:0]       c,
    output logic              learning_done,
    output logic              learning_recall,
    output logic              busy
);

    localparam int CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam int CNT_W = $clog2(NODES_PER_CLASS + 1);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [NODE_W-1:0] bank_q [NUM_CLASSES][NODES_PER_CLASS];
    logic [CNT_W-1:0]  cnt_q  [NUM_CLASSES];
    logic [CNT_W-1:0]  cnt_d  [NUM_CLASSES];
    logic [CLS_W-1:0]  cls_q, cls_d;
    logic [CNT_W-1:0]  node_q, node_d;
    logic              first_q, first_d;
    logic              ready_q;
    logic [NODE_W-1:0] x_q, x_d;
    logic [31:0]       c_q, c_d;
    logic              done_q, done_d;
    logic              ld_err_q, ld_err_d;

    logic              cls_ok, node_ok, wr_en;
    logic [CLS_W-1:0]  wr_cls;
    logic [CNT_W-1:0]  wr_node, wr_node0;
    logic              any_nz, nxt_found;
    logic [CLS_W-1:0]  first_cls, nxt_cls;
    logic [CNT_W-1:0]  node_inc;
    logic              more_nodes, last, skip, issue;
    logic [NODE_W-1:0] cur_vec;

    // Write port: start in the same cycle takes priority and rejects the write.
    always_comb begin
        cls_ok   = (ld_class != '0) && (ld_class <= IDX_W'(NUM_CLASSES));
        node_ok  = (ld_node != '0) && (ld_node <= IDX_W'(NODES_PER_CLASS));
        wr_en    = ld_en && cls_ok && node_ok && (state_q == S_IDLE) && !start;
        ld_err_d = ld_en && !wr_en;
        wr_cls   = CLS_W'(ld_class - 1'b1);
        wr_node  = CNT_W'(ld_node);
        wr_node0 = wr_node - 1'b1;
    end

    // Lowest populated class overall, and lowest populated class above the pointer.
    always_comb begin
        any_nz    = 1'b0;
        nxt_found = 1'b0;
        first_cls = '0;
        nxt_cls   = '0;
        for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
            if (cnt_q[i] != '0) begin
                any_nz    = 1'b1;
                first_cls = CLS_W'(i);
                if (i > int'(cls_q)) begin
                    nxt_found = 1'b1;
                    nxt_cls   = CLS_W'(i);
                end
            end
        end
    end

    assign cur_vec    = bank_q[cls_q][node_q];
    assign node_inc   = node_q + 1'b1;
    assign more_nodes = (node_inc < cnt_q[cls_q]);
    assign last       = !more_nodes && !nxt_found;

`ifdef GAM_ZERO_SKIP_EN
    assign skip = (cur_vec == '0);
`else
    assign skip = 1'b0;
`endif

    // First pattern only needs READY level; later ones need a fresh rising edge.
    assign issue = (first_q ? ready_wait : (ready_wait && !ready_q)) && !skip;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        c_d     = c_q;
        done_d  = done_q;
        cls_d   = cls_q;
        node_d  = node_q;
        first_d = first_q;
        cnt_d   = cnt_q;
        if (wr_en && (wr_node > cnt_q[wr_cls])) begin
            cnt_d[wr_cls] = wr_node;
        end
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start && any_nz) begin
                    state_d = S_FEED;
                    cls_d   = first_cls;
                    node_d  = '0;
                    first_d = 1'b1;
                    done_d  = 1'b0;
                end
            end
            S_FEED: begin
                if (issue || skip) begin
                    if (issue) begin
                        x_d     = cur_vec;
                        c_d     = 32'(cls_q) + 32'd1;
                        first_d = 1'b0;
                    end
                    if (more_nodes) begin
                        node_d = node_inc;
                    end else begin
                        cls_d  = nxt_cls;
                        node_d = '0;
                    end
                    if (last) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            bank_q[wr_cls][wr_node0] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            c_q      <= '0;
            done_q   <= 1'b0;
            ld_err_q <= 1'b0;
            cls_q    <= '0;
            node_q   <= '0;
            first_q  <= 1'b0;
            ready_q  <= 1'b0;
            cnt_q    <= '{default: '0};
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            c_q      <= c_d;
            done_q   <= done_d;
            ld_err_q <= ld_err_d;
            cls_q    <= cls_d;
            node_q   <= node_d;
            first_q  <= first_d;
            ready_q  <= ready_wait;
            cnt_q    <= cnt_d;
        end
    end

    assign x               = x_q;
    assign c               = c_q;
    assign learning_done   = done_q;
    assign learning_recall = (state_q == S_DONE);
    assign busy            = (state_q == S_FEED);
    assign ld_err          = ld_err_q;

endmodule

// File: tb/tb_gam_pattern_feeder.sv
// Bench for gam_pattern_feeder: directed steps with random data/ready against an issue-list model.
module tb_gam_pattern_feeder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ld_en = 1'b0;
    logic [7:0]  ld_class = '0;
    logic [7:0]  ld_node = '0;
    logic [31:0] ld_data = '0;
    logic        ld_err;
    logic        start = 1'b0;
    logic        ready_wait = 1'b0;
    logic [31:0] x;
    logic [31:0] c;
    logic        learning_done;
    logic        learning_recall;
    logic        busy;

    gam_pattern_feeder dut (
        .clk(clk), .reset(reset), .ld_en(ld_en), .ld_class(ld_class), .ld_node(ld_node),
        .ld_data(ld_data), .ld_err(ld_err), .start(start), .ready_wait(ready_wait),
        .x(x), .c(c), .learning_done(learning_done), .learning_recall(learning_recall), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: bank contents, node counts, and the expected issue list of a pass.
    logic [31:0] mb [1:4][1:5];
    int          mcnt [1:4];
    int          qc [$];
    logic [31:0] qv [$];
    int          idx;
    bit          first_pend, model_done, m_idle, prev_rdy;
    logic [31:0] exp_x, exp_c;

`ifdef GAM_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; ld_en = 1'b0; ready_wait = 1'b0;
        tick();
        check("rst_x", x, 0);
        check("rst_c", c, 0);
        check("rst_done", learning_done, 0);
        check("rst_recall", learning_recall, 0);
        check("rst_busy", busy, 0);
        check("rst_ld_err", ld_err, 0);
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) mcnt[k] = 0;
        exp_x = 0; exp_c = 0; model_done = 0; m_idle = 1; prev_rdy = 0;
    endtask

    task automatic load(input int cl, input int nd, input logic [31:0] d);
        bit ok;
        ld_en = 1'b1; ld_class = 8'(cl); ld_node = 8'(nd); ld_data = d;
        tick();
        ld_en = 1'b0;
        prev_rdy = ready_wait;
        ok = (cl >= 1) && (cl <= 4) && (nd >= 1) && (nd <= 5) && m_idle;
        check("ld_err_pulse", ld_err, !ok);
        if (ok) begin
            mb[cl][nd] = d;
            if (nd > mcnt[cl]) mcnt[cl] = nd;
        end
        tick();
        prev_rdy = ready_wait;
        check("ld_err_clear", ld_err, 0);
    endtask

    task automatic start_pass(input bit with_ld);
        bit any;
        any = 0;
        qc.delete(); qv.delete();
        for (int cl = 1; cl <= 4; cl++)
            for (int nd = 1; nd <= mcnt[cl]; nd++) begin
                any = 1;
                if (!(ZS && mb[cl][nd] == 0)) begin
                    qc.push_back(cl);
                    qv.push_back(mb[cl][nd]);
                end
            end
        ready_wait = 1'b0; start = 1'b1;
        if (with_ld) begin
            ld_en = 1'b1; ld_class = 8'd1; ld_node = 8'd5; ld_data = 32'hdead;
        end
        tick();
        start = 1'b0; ld_en = 1'b0; prev_rdy = 0;
        if (with_ld) check("ld_err_start_wins", ld_err, 1);
        if (any) begin
            m_idle = 0; idx = 0; first_pend = 1; model_done = 0;
        end
        check("start_busy", busy, any);
        check("start_done", learning_done, model_done);
    endtask

    // mode 1: random ready and stray start pulses; otherwise ready high for `hold` cycles then toggles every 3.
    task automatic feed(input int mode, input int hold, input int stop_after, input int max_cyc);
        int  cyc;
        int  got;
        bit  r;
        bit  iss;
        cyc = 0; got = 0;
        while (!model_done && cyc < max_cyc && !(stop_after > 0 && got >= stop_after)) begin
            if (mode == 1) begin
                r = 1'($urandom_range(0, 1));
                start = ($urandom_range(0, 7) == 0);
            end else begin
                r = (cyc < hold) ? 1'b1 : 1'(((cyc - hold) / 3) % 2 == 1 || (hold > 0 && ((cyc / 3) % 2 == 1)));
                if (hold == 0) r = 1'((cyc / 3) % 2);
                else r = (cyc < hold) ? 1'b1 : 1'((cyc / 3) % 2);
            end
            ready_wait = r;
            tick();
            start = 1'b0;
            iss = first_pend ? r : (r && !prev_rdy);
            prev_rdy = r;
            if (iss) begin
                exp_x = qv[idx]; exp_c = qc[idx];
                idx++; got++; first_pend = 0;
                if (idx == qc.size()) model_done = 1;
            end
            check("feed_x", x, exp_x);
            check("feed_c", c, exp_c);
            check("feed_done", learning_done, model_done);
            check("feed_recall", learning_recall, model_done);
            check("feed_busy", busy, !model_done);
            cyc++;
        end
        if (stop_after == 0) check("feed_complete", model_done, 1);
        else check("feed_progress", got, stop_after);
    endtask

    initial begin
        do_reset();

        // Class 1 fixed bank: ready held high issues only the first pattern, then toggling walks the rest.
        load(1, 1, 32'h0003);
        load(1, 2, 32'h0400);
        load(1, 3, 32'h070005);
        load(1, 4, 32'h1111);
        start_pass(0);
        feed(0, 6, 0, 200);
        check("pass1_last_x", x, 32'h1111);

        // Writes are rejected in DONE; restart from DONE replays the retained bank.
        load(1, 5, 32'h5555);
        start_pass(0);
        feed(1, 0, 0, 400);

        // Ready edges in IDLE do nothing.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            ready_wait = k[0];
            tick();
            check("idle_x", x, 0);
            check("idle_busy", busy, 0);
        end
        ready_wait = 1'b0;
        tick();

        // Class 2 empty is skipped; rejected writes leave counts alone.
        load(1, 2, $urandom | 32'h1);
        load(1, 1, $urandom | 32'h1);
        load(3, 1, $urandom | 32'h1);
        load(0, 1, 32'h1);
        load(1, 6, 32'h1);
        load(5, 1, 32'h1);
        load(2, 0, 32'h1);
        start_pass(1);
        load(2, 1, 32'h2);
        feed(1, 0, 0, 400);

        // Reset after the second issue aborts; start with cleared counts is ignored.
        start_pass(0);
        feed(1, 0, 2, 400);
        do_reset();
        start_pass(0);
        for (int k = 0; k < 3; k++) begin
            ready_wait = ~ready_wait;
            tick();
            check("post_rst_busy", busy, 0);
            check("post_rst_c", c, 0);
        end
        ready_wait = 1'b0;

        // Zero vector in the middle of a class.
        do_reset();
        load(1, 1, 32'd5);
        load(1, 2, 32'd0);
        load(1, 3, 32'd7);
        start_pass(0);
        feed(2, 0, 0, 200);
        check("zero_last_x", x, ZS ? 32'd7 : 32'd7);
        check("zero_last_done", learning_done, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
